// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache has priority, icache gets forced priority
// after STARVE_LIMIT lost cycles. Tracks load tags and routes returns to their owner.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dcache2ctlr_command,
  input  logic [XLEN-1:0] dcache2ctlr_addr,
  input  logic [63:0]     dcache2ctlr_data,
  input  logic [1:0]      icache2ctlr_command,
  input  logic [XLEN-1:0] icache2ctlr_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      Ctlr2dcache_response,
  output logic [3:0]      Ctlr2icache_response,
  output logic [3:0]      Ctlr2dcache_tag,
  output logic [3:0]      Ctlr2icache_tag,
  output logic [63:0]     Ctlr2dcache_data,
  output logic [63:0]     Ctlr2icache_data,
  output logic [3:0]      dcache_outstanding,
  output logic [3:0]      icache_outstanding,
  output logic            tag_conflict
);

  localparam logic [1:0] BUS_NONE   = 2'd0;
  localparam logic [1:0] BUS_LOAD   = 2'd1;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  localparam logic       OWN_D      = 1'b0;
  localparam logic       OWN_I      = 1'b1;

  logic [2:0]  starve_q, starve_d;
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [3:0]  icnt_q, icnt_d;
  logic        conflict_q, conflict_d;

  logic            d_req, i_req, grant_d, grant_i;
  logic [1:0]      gnt_cmd;
  logic [XLEN-1:0] gnt_addr;
  logic [63:0]     gnt_data;
  logic            alloc, ret_hit, ret_own, overwrite, old_own;
  logic            d_inc, i_inc;
  logic [1:0]      d_dec, i_dec;

  function automatic logic [3:0] next_cnt(input logic [3:0] cur, input logic inc,
                                          input logic [1:0] dec);
    int v;
    v = int'(cur) + int'(inc) - int'(dec);
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  always_comb begin
    d_req   = dcache2ctlr_command != BUS_NONE;
    i_req   = icache2ctlr_command != BUS_NONE;
    grant_i = i_req && (!d_req || starve_q == STARVE_MAX);
    grant_d = d_req && !grant_i;

    gnt_cmd  = BUS_NONE;
    gnt_addr = '0;
    gnt_data = '0;
    if (grant_d) begin
      gnt_cmd  = dcache2ctlr_command;
      gnt_addr = dcache2ctlr_addr;
      gnt_data = dcache2ctlr_data;
    end else if (grant_i) begin
      gnt_cmd  = icache2ctlr_command;
      gnt_addr = icache2ctlr_addr;
    end

    alloc   = (grant_d || grant_i) && mem2proc_response != 4'd0 && gnt_cmd == BUS_LOAD;
    ret_hit = mem2proc_tag != 4'd0 && valid_q[mem2proc_tag];
    ret_own = owner_q[mem2proc_tag];
    old_own = owner_q[mem2proc_response];
    // A tag being returned this cycle is free to reuse; anything else valid is a clash.
    overwrite = alloc && valid_q[mem2proc_response] &&
                !(ret_hit && mem2proc_tag == mem2proc_response);

    starve_d = starve_q;
    if (!i_req || (grant_i && mem2proc_response != 4'd0)) starve_d = 3'd0;
    else if (starve_q < STARVE_MAX) starve_d = starve_q + 3'd1;

    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_i ? OWN_I : OWN_D;
    end

    d_inc = alloc && grant_d;
    i_inc = alloc && grant_i;
    d_dec = {1'b0, ret_hit && ret_own == OWN_D} + {1'b0, overwrite && old_own == OWN_D};
    i_dec = {1'b0, ret_hit && ret_own == OWN_I} + {1'b0, overwrite && old_own == OWN_I};
    dcnt_d = next_cnt(dcnt_q, d_inc, d_dec);
    icnt_d = next_cnt(icnt_q, i_inc, i_dec);

    conflict_d = conflict_q || overwrite;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q   <= '0;
      valid_q    <= '0;
      owner_q    <= '0;
      dcnt_q     <= '0;
      icnt_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      dcnt_q     <= dcnt_d;
      icnt_q     <= icnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    proc2mem_command     = reset ? BUS_NONE : gnt_cmd;
    proc2mem_addr        = reset ? '0 : gnt_addr;
    proc2mem_data        = reset ? '0 : gnt_data;
    Ctlr2dcache_response = (!reset && grant_d) ? mem2proc_response : 4'd0;
    Ctlr2icache_response = (!reset && grant_i) ? mem2proc_response : 4'd0;
    Ctlr2dcache_tag      = 4'd0;
    Ctlr2icache_tag      = 4'd0;
    Ctlr2dcache_data     = '0;
    Ctlr2icache_data     = '0;
    if (!reset && ret_hit) begin
      if (ret_own == OWN_I) begin
        Ctlr2icache_tag  = mem2proc_tag;
        Ctlr2icache_data = mem2proc_data;
      end else begin
        Ctlr2dcache_tag  = mem2proc_tag;
        Ctlr2dcache_data = mem2proc_data;
      end
    end
  end

  assign dcache_outstanding = dcnt_q;
  assign icache_outstanding = icnt_q;
  assign tag_conflict       = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked against a tag-table reference model.
module tb_mem_arbiter;
  localparam int SL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dcache2ctlr_command = '0;
  logic [31:0] dcache2ctlr_addr = '0;
  logic [63:0] dcache2ctlr_data = '0;
  logic [1:0]  icache2ctlr_command = '0;
  logic [31:0] icache2ctlr_addr = '0;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  Ctlr2dcache_response, Ctlr2icache_response;
  logic [3:0]  Ctlr2dcache_tag, Ctlr2icache_tag;
  logic [63:0] Ctlr2dcache_data, Ctlr2icache_data;
  logic [3:0]  dcache_outstanding, icache_outstanding;
  logic        tag_conflict;

  int checks = 0;
  int failures = 0;

  // Reference state: which tags are in flight and who owns them (1 = icache).
  bit m_valid[16];
  bit m_owner[16];
  int m_starve;
  bit m_conf;

  mem_arbiter #(.STARVE_LIMIT(SL), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .dcache2ctlr_command(dcache2ctlr_command), .dcache2ctlr_addr(dcache2ctlr_addr),
    .dcache2ctlr_data(dcache2ctlr_data),
    .icache2ctlr_command(icache2ctlr_command), .icache2ctlr_addr(icache2ctlr_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .Ctlr2dcache_response(Ctlr2dcache_response), .Ctlr2icache_response(Ctlr2icache_response),
    .Ctlr2dcache_tag(Ctlr2dcache_tag), .Ctlr2icache_tag(Ctlr2icache_tag),
    .Ctlr2dcache_data(Ctlr2dcache_data), .Ctlr2icache_data(Ctlr2icache_data),
    .dcache_outstanding(dcache_outstanding), .icache_outstanding(icache_outstanding),
    .tag_conflict(tag_conflict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    dcache2ctlr_command = 2'd0; dcache2ctlr_addr = '0; dcache2ctlr_data = '0;
    icache2ctlr_command = 2'd0; icache2ctlr_addr = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic set_random();
    dcache2ctlr_command = 2'($urandom_range(0, 2));
    dcache2ctlr_addr    = $urandom;
    dcache2ctlr_data    = {$urandom, $urandom};
    icache2ctlr_command = 2'($urandom_range(0, 1));
    icache2ctlr_addr    = $urandom;
    mem2proc_response   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    mem2proc_data       = {$urandom, $urandom};
    mem2proc_tag        = 4'($urandom_range(0, 15));
  endtask

  // Hold reset for one edge with random inputs; every output must read zero.
  task automatic do_reset();
    reset = 1'b1;
    set_random();
    #2;
    chk("rst_cmd", 64'(proc2mem_command), 64'd0);
    chk("rst_addr", 64'(proc2mem_addr), 64'd0);
    chk("rst_data", proc2mem_data, 64'd0);
    chk("rst_dresp", 64'(Ctlr2dcache_response), 64'd0);
    chk("rst_iresp", 64'(Ctlr2icache_response), 64'd0);
    chk("rst_dtag", 64'({Ctlr2dcache_tag, Ctlr2icache_tag}), 64'd0);
    chk("rst_rdata", Ctlr2dcache_data | Ctlr2icache_data, 64'd0);
    chk("rst_cnt", 64'({dcache_outstanding, icache_outstanding}), 64'd0);
    chk("rst_conf", 64'(tag_conflict), 64'd0);
    @(posedge clock); #1;
    for (int t = 0; t < 16; t++) begin m_valid[t] = 0; m_owner[t] = 0; end
    m_starve = 0;
    m_conf = 0;
    set_idle();
    reset = 1'b0;
  endtask

  // Check all outputs against the model for the current inputs, then clock once.
  task automatic run_cycle();
    bit dreq, ireq, gd, gi, rhit, acc_load, clash;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    int ndc, nic;
    #2;
    dreq = dcache2ctlr_command != 0;
    ireq = icache2ctlr_command != 0;
    gi = ireq && (!dreq || m_starve == SL);
    gd = dreq && !gi;
    e_cmd  = gd ? dcache2ctlr_command : (gi ? icache2ctlr_command : 2'd0);
    e_addr = gd ? dcache2ctlr_addr : (gi ? icache2ctlr_addr : 32'd0);
    e_data = gd ? dcache2ctlr_data : 64'd0;
    rhit = mem2proc_tag != 0 && m_valid[mem2proc_tag];
    ndc = 0; nic = 0;
    for (int t = 1; t < 16; t++) if (m_valid[t]) begin
      if (m_owner[t]) nic++; else ndc++;
    end
    chk("cmd", 64'(proc2mem_command), 64'(e_cmd));
    chk("addr", 64'(proc2mem_addr), 64'(e_addr));
    chk("pdata", proc2mem_data, e_data);
    chk("dresp", 64'(Ctlr2dcache_response), gd ? 64'(mem2proc_response) : 64'd0);
    chk("iresp", 64'(Ctlr2icache_response), gi ? 64'(mem2proc_response) : 64'd0);
    chk("dtag", 64'(Ctlr2dcache_tag), (rhit && !m_owner[mem2proc_tag]) ? 64'(mem2proc_tag) : 64'd0);
    chk("itag", 64'(Ctlr2icache_tag), (rhit && m_owner[mem2proc_tag]) ? 64'(mem2proc_tag) : 64'd0);
    chk("ddata", Ctlr2dcache_data, (rhit && !m_owner[mem2proc_tag]) ? mem2proc_data : 64'd0);
    chk("idata", Ctlr2icache_data, (rhit && m_owner[mem2proc_tag]) ? mem2proc_data : 64'd0);
    chk("dcnt", 64'(dcache_outstanding), 64'(ndc));
    chk("icnt", 64'(icache_outstanding), 64'(nic));
    chk("conf", 64'(tag_conflict), 64'(m_conf));
    @(posedge clock); #1;
    if (!ireq || (gi && mem2proc_response != 0)) m_starve = 0;
    else if (m_starve < SL) m_starve++;
    acc_load = (gd || gi) && mem2proc_response != 0 && e_cmd == 2'd1;
    clash = acc_load && m_valid[mem2proc_response] && !(rhit && mem2proc_tag == mem2proc_response);
    if (clash) m_conf = 1;
    if (rhit) m_valid[mem2proc_tag] = 0;
    if (acc_load) begin
      m_valid[mem2proc_response] = 1;
      m_owner[mem2proc_response] = gi;
    end
  endtask

  initial begin
    set_idle();
    do_reset();

    // Simultaneous requests: dcache wins and gets the tag.
    dcache2ctlr_command = 2'd1; dcache2ctlr_addr = 32'h100;
    icache2ctlr_command = 2'd1; icache2ctlr_addr = 32'h200;
    mem2proc_response = 4'd3;
    #1;
    chk("ex1_addr", 64'(proc2mem_addr), 64'h100);
    chk("ex1_dresp", 64'(Ctlr2dcache_response), 64'd3);
    chk("ex1_iresp", 64'(Ctlr2icache_response), 64'd0);
    run_cycle();
    set_idle();
    chk("ex1_dcnt", 64'(dcache_outstanding), 64'd1);
    run_cycle();

    // Starvation: icache is forced through on the fifth losing attempt.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      dcache2ctlr_command = 2'd1; dcache2ctlr_addr = 32'h100;
      icache2ctlr_command = 2'd1; icache2ctlr_addr = 32'h200;
      mem2proc_response = 4'd0;
      #1;
      chk("starve_grant", 64'(proc2mem_addr), (i >= 5) ? 64'h200 : 64'h100);
      run_cycle();
    end
    set_idle();
    run_cycle();

    // icache-owned tag 5 returns with 0xDEAD.
    do_reset();
    icache2ctlr_command = 2'd1; icache2ctlr_addr = 32'h40; mem2proc_response = 4'd5;
    run_cycle();
    set_idle();
    chk("ret5_icnt_before", 64'(icache_outstanding), 64'd1);
    mem2proc_tag = 4'd5; mem2proc_data = 64'hDEAD;
    #1;
    chk("ret5_itag", 64'(Ctlr2icache_tag), 64'd5);
    chk("ret5_idata", Ctlr2icache_data, 64'hDEAD);
    chk("ret5_dtag", 64'(Ctlr2dcache_tag), 64'd0);
    run_cycle();
    set_idle();
    chk("ret5_icnt_after", 64'(icache_outstanding), 64'd0);
    mem2proc_tag = 4'd5; mem2proc_data = 64'h1234;
    #1;
    chk("ret5_dropped", 64'({Ctlr2dcache_tag, Ctlr2icache_tag}), 64'd0);
    run_cycle();

    // Return of tag 7 and re-acceptance of tag 7 in the same cycle.
    do_reset();
    icache2ctlr_command = 2'd1; mem2proc_response = 4'd7;
    run_cycle();
    set_idle();
    dcache2ctlr_command = 2'd1; dcache2ctlr_addr = 32'h700; mem2proc_response = 4'd7;
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    run_cycle();
    set_idle();
    chk("reuse7_conf", 64'(tag_conflict), 64'd0);
    chk("reuse7_cnt", 64'({dcache_outstanding, icache_outstanding}), 64'h10);
    mem2proc_tag = 4'd7; mem2proc_data = 64'h99;
    #1;
    chk("reuse7_owner", 64'(Ctlr2dcache_tag), 64'd7);
    run_cycle();

    // Double acceptance of tag 9 makes tag_conflict stick until reset.
    do_reset();
    dcache2ctlr_command = 2'd1; mem2proc_response = 4'd9;
    run_cycle();
    icache2ctlr_command = 2'd1; dcache2ctlr_command = 2'd0; mem2proc_response = 4'd9;
    run_cycle();
    set_idle();
    chk("dup9_conf", 64'(tag_conflict), 64'd1);
    chk("dup9_cnt", 64'({dcache_outstanding, icache_outstanding}), 64'h01);
    for (int i = 0; i < 3; i++) run_cycle();
    chk("dup9_sticky", 64'(tag_conflict), 64'd1);
    do_reset();
    chk("dup9_cleared", 64'(tag_conflict), 64'd0);

    // Reset with loads outstanding; a later return of an old tag is dropped.
    for (int t = 1; t <= 3; t++) begin
      dcache2ctlr_command = (t == 2) ? 2'd0 : 2'd1;
      icache2ctlr_command = (t == 2) ? 2'd1 : 2'd0;
      mem2proc_response = 4'(t);
      run_cycle();
    end
    set_idle();
    chk("rst3_cnt_pre", 64'({dcache_outstanding, icache_outstanding}), 64'h21);
    do_reset();
    chk("rst3_cnt_post", 64'({dcache_outstanding, icache_outstanding}), 64'h00);
    mem2proc_tag = 4'd2; mem2proc_data = 64'hBEEF;
    #1;
    chk("rst3_dropped", 64'({Ctlr2dcache_tag, Ctlr2icache_tag}), 64'd0);
    run_cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      set_random();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles icache may lose arbitration before it gets forced priority.
REQ-002 Parameter XLEN, default 32: address width.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 dcache2ctlr_command  in  2  BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2 from dcache.
REQ-006 dcache2ctlr_addr  in  XLEN  dcache request address; dcache2ctlr_data in 64, store data.
REQ-007 icache2ctlr_command  in  2  icache request, BUS_NONE or BUS_LOAD only; icache2ctlr_addr in XLEN.
REQ-008 mem2proc_response  in  4  nonzero = request accepted, value = assigned tag (1..15).
REQ-009 mem2proc_data  in  64 and mem2proc_tag  in  4  load return; tag 0 = no return.
REQ-010 proc2mem_command  out  2, proc2mem_addr  out  XLEN, proc2mem_data  out  64  granted request.
REQ-011 Ctlr2dcache_response / Ctlr2icache_response  out  4  acceptance tag to the granted requester only.
REQ-012 Ctlr2dcache_tag / Ctlr2icache_tag  out  4, Ctlr2dcache_data / Ctlr2icache_data  out  64  routed load returns.
REQ-013 dcache_outstanding / icache_outstanding  out  4  count of accepted, unreturned loads per requester.
REQ-014 tag_conflict  out  1  sticky error flag.

Function
REQ-015 Grant is combinational within the cycle; a requester requests when its command != BUS_NONE.
REQ-016 Default priority: dcache; icache wins only when dcache is idle or starve_cnt == STARVE_LIMIT.
REQ-017 starve_cnt (3 bits, saturating at STARVE_LIMIT): +1 on each cycle icache requests and is not granted, or is granted but mem2proc_response == 0; cleared on each cycle icache is granted with mem2proc_response != 0, and on any cycle icache does not request.
REQ-018 proc2mem_* mirror the granted requester's fields; proc2mem_data = dcache data when dcache is granted, else 0; all zero when there is no grant.
REQ-019 Ctlr2<granted>_response = mem2proc_response; the non-granted requester sees 0 the same cycle.
REQ-020 Owner table: 16 entries {valid, owner}; entry 0 is never written.
REQ-021 Accepted BUS_LOAD (response != 0) sets entry[response] = {1, granted requester} at the next edge; accepted BUS_STORE allocates nothing.
REQ-022 When mem2proc_tag != 0 and entry[tag].valid: drive tag/data to the owner's outputs the same cycle, others 0; clear entry at the next edge.
REQ-023 mem2proc_tag with an invalid entry is dropped: both tag outputs 0.
REQ-024 Same-cycle return of tag T and new acceptance of tag T: the allocation wins, entry[T] ends valid with the new owner.
REQ-025 Acceptance of a tag whose entry is already valid, unless it is being returned that cycle: the entry is overwritten, the old owner's count is decremented, and tag_conflict is set until reset.
REQ-026 Outstanding counters: +1 on allocation, -1 on routed return, net 0 when both occur together; range 0..15, no wrap.
REQ-027 Data outputs to a requester are 0 whenever its tag output is 0.

Reset
REQ-028 While reset is high: table cleared, starve_cnt=0, counters=0, tag_conflict=0.
REQ-029 While reset is high, all outputs are 0; proc2mem_command=BUS_NONE.
REQ-030 A return arriving after reset deasserts for a pre-reset tag is dropped per REQ-023.

Verification
REQ-031 Dcache LOAD 0x100 and icache LOAD 0x200 together, response=3 -> proc2mem_addr=0x100, Ctlr2dcache_response=3, Ctlr2icache_response=0; next cycle dcache_outstanding=1.
REQ-032 Continuous dcache requests with response=0, icache held requesting, STARVE_LIMIT=4 -> icache granted on the 5th cycle.
REQ-033 Tag 5 owned by icache, mem2proc_tag=5 with data 0xDEAD -> Ctlr2icache_tag=5, Ctlr2icache_data=0xDEAD, Ctlr2dcache_tag=0; entry 5 cleared and icache_outstanding decremented.
REQ-034 Return tag 7 and accept a new dcache load with response=7 in the same cycle -> entry 7 valid and owned by dcache, tag_conflict stays 0.
REQ-035 Accept tag 9 twice with no return in between -> tag_conflict=1, and it stays 1 until reset.
REQ-036 Assert reset with 3 loads outstanding, then return one of their tags -> counters 0 and the return is dropped.
